// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the sweep controller, the up/down
// counter and their benches.
//   WIDTH_DEF / REP_W_DEF : default data / repeat-count widths
//   CNT_UP / CNT_DOWN     : counter direction encoding on updown
//   sweep_state_t         : sweep controller state encoding
package counter_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int REP_W_DEF = 4;

  localparam logic CNT_UP   = 1'b0;
  localparam logic CNT_DOWN = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    UP     = 3'd2,
    DOWN   = 3'd3,
    FINISH = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/updown_counter.sv
// updown_counter: loadable up/down counter driven by the sweep controller.
//   i_clk, i_rst_sync : clock, synchronous active-high reset (clears to 0)
//   i_load/i_value_in : load value_in (has priority over counting)
//   i_enable/i_updown : count when enabled; updown 0 = up, 1 = down
//   o_value_out       : current count
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_sync,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value_in,
  input  logic             i_enable,
  input  logic             i_updown,
  output logic [WIDTH-1:0] o_value_out
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_value_in;
    end else if (i_enable) begin
      if (i_updown == CNT_DOWN) r_value <= r_value - WIDTH'(1);
      else                      r_value <= r_value + WIDTH'(1);
    end
  end

  assign o_value_out = r_value;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an up/down counter through a lo->hi->lo
// triangle sweep, repeated reps times, then pulses done for one cycle.
//   i_clk, i_rst_sync        : clock, synchronous active-high reset
//   i_start / i_stop         : start a run (IDLE only) / abort a run
//   i_lim_lo/i_lim_hi/i_reps : sweep limits and repeat count, latched on start
//   i_cnt_value              : counter value feedback
//   o_cnt_load/o_cnt_value_in/o_cnt_enable/o_cnt_updown : counter controls
//   o_busy, o_done, o_err    : status (err is sticky for a rejected start)
//   o_sweeps_done            : completed sweeps in the current run
//
// state  | meaning
// IDLE   | waiting for start, counter controls idle
// LOAD   | counter loads the latched lo
// UP     | counting up until the counter reaches hi
// DOWN   | counting down until the counter reaches lo, then count a sweep
// FINISH | one-cycle done pulse, counter holds lo
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_sync,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [WIDTH-1:0] i_lim_lo,
  input  logic [WIDTH-1:0] i_lim_hi,
  input  logic [REP_W-1:0] i_reps,
  input  logic [WIDTH-1:0] i_cnt_value,
  output logic             o_cnt_load,
  output logic [WIDTH-1:0] o_cnt_value_in,
  output logic             o_cnt_enable,
  output logic             o_cnt_updown,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [REP_W-1:0] o_sweeps_done
);

  sweep_state_t     r_state;
  sweep_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_sweeps;
  logic             r_err;

  logic             w_start_ok;
  logic             w_accept;
  logic             w_reject;
  logic             w_sweep_inc;
  logic [WIDTH-1:0] w_hi_m1;
  logic [WIDTH-1:0] w_lo_p1;
  logic [REP_W-1:0] w_sweeps_p1;

  assign w_start_ok  = (i_lim_hi > i_lim_lo) && (i_reps != '0);
  assign w_hi_m1     = r_hi - WIDTH'(1);
  assign w_lo_p1     = r_lo + WIDTH'(1);
  assign w_sweeps_p1 = r_sweeps + REP_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_reps   <= '0;
      r_sweeps <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_lo     <= i_lim_lo;
        r_hi     <= i_lim_hi;
        r_reps   <= i_reps;
        r_sweeps <= '0;
        r_err    <= 1'b0;
      end else if (w_reject) begin
        r_err <= 1'b1;
      end
      if (w_sweep_inc) r_sweeps <= w_sweeps_p1;
    end
  end

  // The turn-around compares look one step ahead (hi-1, lo+1) so the counter
  // lands on hi / lo on the same edge that the state changes direction.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_sweep_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) begin
          if (w_start_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      LOAD:   w_state_nxt = UP;
      UP: begin
        if (i_cnt_value == w_hi_m1) w_state_nxt = DOWN;
      end
      DOWN: begin
        if (i_cnt_value == w_lo_p1) begin
          w_sweep_inc = 1'b1;
          w_state_nxt = (w_sweeps_p1 == r_reps) ? FINISH : UP;
        end
      end
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Abort wins over everything; an aborted turn is not counted as a sweep.
    if (i_stop && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_sweep_inc = 1'b0;
    end
  end

  always_comb begin
    o_cnt_load   = 1'b0;
    o_cnt_enable = 1'b0;
    o_cnt_updown = CNT_UP;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      LOAD: begin
        o_cnt_load   = 1'b1;
        o_cnt_enable = 1'b1;
        o_busy       = 1'b1;
      end
      UP: begin
        o_cnt_enable = 1'b1;
        o_busy       = 1'b1;
      end
      DOWN: begin
        o_cnt_enable = 1'b1;
        o_cnt_updown = CNT_DOWN;
        o_busy       = 1'b1;
      end
      FINISH:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_cnt_value_in = r_lo;
  assign o_err          = r_err;
  assign o_sweeps_done  = r_sweeps;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;
  import counter_pkg::*;

  localparam int W = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_sync;
  logic         start, stop;
  logic [W-1:0] lim_lo, lim_hi;
  logic [R-1:0] reps;
  logic [W-1:0] cnt_value, cnt_value_in;
  logic         cnt_load, cnt_enable, cnt_updown;
  logic         busy, done, err;
  logic [R-1:0] sweeps_done;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.WIDTH(W), .REP_W(R)) u_ctrl (
    .i_clk(clk), .i_rst_sync(rst_sync), .i_start(start), .i_stop(stop),
    .i_lim_lo(lim_lo), .i_lim_hi(lim_hi), .i_reps(reps), .i_cnt_value(cnt_value),
    .o_cnt_load(cnt_load), .o_cnt_value_in(cnt_value_in), .o_cnt_enable(cnt_enable),
    .o_cnt_updown(cnt_updown), .o_busy(busy), .o_done(done), .o_err(err),
    .o_sweeps_done(sweeps_done)
  );

  updown_counter #(.WIDTH(W)) u_cnt (
    .i_clk(clk), .i_rst_sync(rst_sync), .i_load(cnt_load), .i_value_in(cnt_value_in),
    .i_enable(cnt_enable), .i_updown(cnt_updown), .o_value_out(cnt_value)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] cnt;
    logic [W-1:0] vin;
    logic         ld, en, ud, bsy, dn, er;
    logic [R-1:0] sw;
  } exp_t;

  typedef struct {
    int lo, hi, n;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bench-side record of what the design should be holding between runs.
  int last_cnt = 0, last_lo = 0, last_sw = 0;
  bit last_err = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(string name, int c, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endfunction

  function automatic void compare(exp_t e);
    chk("cnt_value",    e.cyc, int'(cnt_value),    int'(e.cnt));
    chk("cnt_value_in", e.cyc, int'(cnt_value_in), int'(e.vin));
    chk("cnt_load",     e.cyc, int'(cnt_load),     int'(e.ld));
    chk("cnt_enable",   e.cyc, int'(cnt_enable),   int'(e.en));
    chk("cnt_updown",   e.cyc, int'(cnt_updown),   int'(e.ud));
    chk("busy",         e.cyc, int'(busy),         int'(e.bsy));
    chk("done",         e.cyc, int'(done),         int'(e.dn));
    chk("err",          e.cyc, int'(err),          int'(e.er));
    chk("sweeps_done",  e.cyc, int'(sweeps_done),  int'(e.sw));
  endfunction

  // Triangle position: cycle 2 shows lo, cycle 2+S shows hi, period 2S.
  function automatic int tri_val(int c, int lo, int s);
    int p;
    p = (c - 2) % (2 * s);
    return (p <= s) ? lo + p : lo + 2 * s - p;
  endfunction

  function automatic exp_t idle_rec(int c, int cnt, int vin, bit er, int sw);
    exp_t e;
    e.cyc = c; e.cnt = W'(cnt); e.vin = W'(vin);
    e.ld = 0; e.en = 0; e.ud = 0; e.bsy = 0; e.dn = 0; e.er = er; e.sw = R'(sw);
    return e;
  endfunction

  // Expected outputs of an uninterrupted accepted run in cycle c (c >= 1).
  function automatic exp_t run_rec(int c, int lo, int hi, int n);
    exp_t e;
    int s, d, p;
    s = hi - lo;
    d = 2 + 2 * n * s;
    e = idle_rec(c, lo, lo, 1'b0, n);
    if (c == 1) begin
      e.cnt = W'(last_cnt); e.ld = 1; e.en = 1; e.bsy = 1; e.sw = '0;
    end else if (c < d) begin
      p = (c - 2) % (2 * s);
      e.cnt = W'(tri_val(c, lo, s)); e.en = 1; e.bsy = 1;
      e.ud = (p >= s) ? CNT_DOWN : CNT_UP;
      e.sw = R'((c - 2) / (2 * s));
    end else if (c == d) begin
      e.dn = 1;
    end
    return e;
  endfunction

  // Start in cycle 0, then optional stop / reset / stray start in later cycles.
  task automatic run_case(int lo, int hi, int n, int stop_k, int rst_k, int busy_k);
    bit ok;
    int s, last_c, fcnt;
    exp_t e;
    ok = (hi > lo) && (n != 0);
    s  = hi - lo;
    if (!ok)             last_c = 2;
    else if (rst_k >= 0)  last_c = rst_k + 2;
    else if (stop_k >= 0) last_c = stop_k + 4;
    else                  last_c = 3 + 2 * n * s;
    for (int c = 1; c <= last_c; c++) begin
      if (!ok)
        e = idle_rec(c, last_cnt, last_lo, 1'b1, last_sw);
      else if (rst_k >= 0 && c > rst_k)
        e = idle_rec(c, 0, 0, 1'b0, 0);
      else if (stop_k >= 0 && c > stop_k)
        // The counter takes one last step on the edge that samples stop.
        e = idle_rec(c, tri_val(stop_k + 1, lo, s), lo, 1'b0, (stop_k - 2) / (2 * s));
      else
        e = run_rec(c, lo, hi, n);
      q.push_back(e);
    end
    lim_lo = W'(lo); lim_hi = W'(hi); reps = R'(n); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      stop = (c == stop_k);
      rst_sync = (c == rst_k);
      if (c == busy_k) begin
        lim_lo = 8'd50; lim_hi = 8'd40; reps = '0; start = 1'b1;
      end
      e = q.pop_front();
      compare(e);
      step();
      stop = 1'b0; rst_sync = 1'b0; start = 1'b0;
    end
    last_cnt = int'(e.cnt); last_lo = int'(e.vin); last_sw = int'(e.sw); last_err = e.er;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{lo: 10, hi: 13,  n: 2};
    vecs[1] = '{lo: 0,  hi: 255, n: 1};
    vecs[2] = '{lo: 5,  hi: 6,   n: 3};
    vecs[3] = '{lo: 20, hi: 20,  n: 1};
    vecs[4] = '{lo: 7,  hi: 9,   n: 0};
    vecs[5] = '{lo: 30, hi: 10,  n: 2};
    vecs[6] = '{lo: 3,  hi: 8,   n: 1};

    rst_sync = 1'b1; start = 1'b0; stop = 1'b0;
    lim_lo = '0; lim_hi = '0; reps = '0;
    step(); step();
    rst_sync = 1'b0;
    step();
    q.push_back(idle_rec(0, 0, 0, 1'b0, 0));
    compare(q.pop_front());

    for (int i = 0; i < 7; i++)
      run_case(vecs[i].lo, vecs[i].hi, vecs[i].n, -1, -1, -1);

    run_case(10, 13, 2, 6, -1, -1);   // abort mid-sweep
    run_case(7, 9, 0, -1, -1, -1);    // reject again, err set
    run_case(10, 13, 2, -1, 4, -1);   // reset mid-sweep clears err too
    run_case(10, 13, 2, -1, -1, 5);   // bogus start while busy is ignored

    // Counter must stay frozen in IDLE.
    for (int i = 0; i < 3; i++) begin
      q.push_back(idle_rec(i, last_cnt, last_lo, last_err, last_sw));
      compare(q.pop_front());
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
